// File: rtl/ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_stage: execute stage with 1-cycle ALU and optional 32-cycle MUL       |
// | (enabled by EX_MUL_EN); result held until the downstream stage takes it. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ex_stage (
    input  logic        clk,
    input  logic        res_n,
    input  logic        id_ex_valid,
    input  logic [7:0]  id_ex_control,
    input  logic [31:0] id_ex0,
    input  logic [31:0] id_ex1,
    output logic        id_ex_ready,
    input  logic        mem_ready,
    output logic        ex_mem_valid,
    output logic [31:0] ex_mem_result,
    output logic [7:0]  ex_mem_control,
    output logic        ex_mem_zero,
    output logic        ex_mem_illegal
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
`ifdef EX_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'd10;
`endif
    localparam logic [3:0] OP_PASSB = 4'd11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  control_q, control_d;
    logic        zero_q, zero_d;
    logic        illegal_q, illegal_d;

`ifdef EX_MUL_EN
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [7:0]  mctl_q, mctl_d;
    logic [31:0] acc_next;
`endif

    logic [3:0]  op;
    logic [4:0]  shamt;
    logic        accept;
    logic [31:0] alu_result;
    logic        alu_illegal;

    assign op     = id_ex_control[3:0];
    assign shamt  = id_ex1[4:0];
    assign id_ex_ready = (state_q == IDLE) && (!valid_q || mem_ready);
    assign accept = id_ex_valid && id_ex_ready;

    assign ex_mem_valid   = valid_q;
    assign ex_mem_result  = result_q;
    assign ex_mem_control = control_q;
    assign ex_mem_zero    = zero_q;
    assign ex_mem_illegal = illegal_q;

    // Op 10 lands in default here; with EX_MUL_EN the sequential path claims it first.
    always_comb begin
        alu_result  = 32'd0;
        alu_illegal = 1'b0;
        case (op)
            OP_ADD:   alu_result = id_ex0 + id_ex1;
            OP_SUB:   alu_result = id_ex0 - id_ex1;
            OP_SLL:   alu_result = id_ex0 << shamt;
            OP_SLT:   alu_result = {31'd0, $signed(id_ex0) < $signed(id_ex1)};
            OP_SLTU:  alu_result = {31'd0, id_ex0 < id_ex1};
            OP_XOR:   alu_result = id_ex0 ^ id_ex1;
            OP_SRL:   alu_result = id_ex0 >> shamt;
            OP_SRA:   alu_result = $unsigned($signed(id_ex0) >>> shamt);
            OP_OR:    alu_result = id_ex0 | id_ex1;
            OP_AND:   alu_result = id_ex0 & id_ex1;
            OP_PASSB: alu_result = id_ex1;
            default:  alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        result_d  = result_q;
        control_d = control_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef EX_MUL_EN
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        mctl_d    = mctl_q;
        acc_next  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
`endif

        if (valid_q && mem_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef EX_MUL_EN
                    if (op == OP_MUL) begin
                        state_d  = BUSY;
                        cnt_d    = 6'd0;
                        mcand_d  = id_ex0;
                        mplier_d = id_ex1;
                        acc_d    = 32'd0;
                        mctl_d   = id_ex_control;
                    end else
`endif
                    begin
                        valid_d   = 1'b1;
                        result_d  = alu_result;
                        control_d = id_ex_control;
                        zero_d    = (alu_result == 32'd0);
                        illegal_d = alu_illegal;
                    end
                end
            end
            BUSY: begin
`ifdef EX_MUL_EN
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                // Final iteration folds straight into the output register.
                if (cnt_q == 6'd31) begin
                    state_d   = IDLE;
                    valid_d   = 1'b1;
                    result_d  = acc_next;
                    control_d = mctl_q;
                    zero_d    = (acc_next == 32'd0);
                    illegal_d = 1'b0;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            result_q  <= 32'd0;
            control_q <= 8'd0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef EX_MUL_EN
            cnt_q     <= 6'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            acc_q     <= 32'd0;
            mctl_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            control_q <= control_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifdef EX_MUL_EN
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            mctl_q    <= mctl_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_stage: directed and random stimulus against a transaction model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        res_n;
    logic        id_ex_valid;
    logic [7:0]  id_ex_control;
    logic [31:0] id_ex0;
    logic [31:0] id_ex1;
    logic        id_ex_ready;
    logic        mem_ready;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_result;
    logic [7:0]  ex_mem_control;
    logic        ex_mem_zero;
    logic        ex_mem_illegal;

    always #5 clk = ~clk;

    ex_stage u_dut (
        .clk            (clk),
        .res_n          (res_n),
        .id_ex_valid    (id_ex_valid),
        .id_ex_control  (id_ex_control),
        .id_ex0         (id_ex0),
        .id_ex1         (id_ex1),
        .id_ex_ready    (id_ex_ready),
        .mem_ready      (mem_ready),
        .ex_mem_valid   (ex_mem_valid),
        .ex_mem_result  (ex_mem_result),
        .ex_mem_control (ex_mem_control),
        .ex_mem_zero    (ex_mem_zero),
        .ex_mem_illegal (ex_mem_illegal)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: visible outputs plus the remaining cycles of a pending multiply.
    logic        m_valid;
    logic [31:0] m_result;
    logic [7:0]  m_control;
    logic        m_zero;
    logic        m_illegal;
    int          m_busy;
    logic [31:0] m_a, m_b;
    logic [7:0]  m_ctl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_result = 32'd0; m_control = 8'd0;
        m_zero = 1'b0; m_illegal = 1'b0; m_busy = 0;
    endtask

    task automatic model_write(input logic [31:0] r, input logic [7:0] ctl, input logic ill);
        m_valid = 1'b1; m_result = r; m_control = ctl;
        m_zero = (r == 32'd0); m_illegal = ill;
    endtask

    // Returns {illegal, result}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, sh;
        sa = a; sb = b; sh = int'(b % 32);
        case (op)
            4'd0:  return {1'b0, a + b};
            4'd1:  return {1'b0, a - b};
            4'd2:  return {1'b0, a << sh};
            4'd3:  return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
            4'd4:  return {1'b0, (a < b) ? 32'd1 : 32'd0};
            4'd5:  return {1'b0, a ^ b};
            4'd6:  return {1'b0, a >> sh};
            4'd7:  return {1'b0, a[31] ? ~((~a) >> sh) : (a >> sh)};
            4'd8:  return {1'b0, a | b};
            4'd9:  return {1'b0, a & b};
            4'd11: return {1'b0, b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},   {31'd0, ex_mem_valid},   {31'd0, m_valid});
        check({tag, ".result"},  ex_mem_result,           m_result);
        check({tag, ".control"}, {24'd0, ex_mem_control}, {24'd0, m_control});
        check({tag, ".zero"},    {31'd0, ex_mem_zero},    {31'd0, m_zero});
        check({tag, ".illegal"}, {31'd0, ex_mem_illegal}, {31'd0, m_illegal});
    endtask

    // One clock: drive at the falling edge, check ready, clock, check outputs.
    task automatic step(input logic v, input logic [7:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic mr);
        logic        rdy;
        logic [32:0] r;
        id_ex_valid = v; id_ex_control = ctl; id_ex0 = a; id_ex1 = b; mem_ready = mr;
        #1;
        rdy = (m_busy == 0) && (!m_valid || mr);
        check("ready", {31'd0, id_ex_ready}, {31'd0, rdy});
        @(posedge clk);
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) model_write(m_a * m_b, m_ctl, 1'b0);
            else if (m_valid && mr) m_valid = 1'b0;
        end else if (v && rdy) begin
`ifdef EX_MUL_EN
            if (ctl[3:0] == 4'd10) begin
                m_busy = 32; m_a = a; m_b = b; m_ctl = ctl; m_valid = 1'b0;
            end else
`endif
            begin
                r = ref_alu(ctl[3:0], a, b);
                model_write(r[31:0], ctl, r[32]);
            end
        end else if (m_valid && mr) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs("out");
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release at a falling edge.
    task automatic pulse_reset();
        #2 res_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        check("rst.ready", {31'd0, id_ex_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        res_n = 1'b0; id_ex_valid = 1'b0; id_ex_control = 8'd0;
        id_ex0 = 32'd0; id_ex1 = 32'd0; mem_ready = 1'b1;
        model_reset();
        #2;
        check_outputs("por");
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
        #1 check("ready_after_rst", {31'd0, id_ex_ready}, 32'd1);

        // Boundary values with fixed expectations.
        step(1'b1, 8'h00, 32'h7FFF_FFFF, 32'd1, 1'b1);
        check("add_ovf", ex_mem_result, 32'h8000_0000);
        check("add_ovf.zero", {31'd0, ex_mem_zero}, 32'd0);
        step(1'b1, 8'h11, 32'd5, 32'd5, 1'b1);
        check("sub_zero", {31'd0, ex_mem_zero}, 32'd1);
        check("sub_ctl", {24'd0, ex_mem_control}, 32'h11);
        step(1'b1, 8'h07, 32'h8000_0000, 32'h24, 1'b1);
        check("sra", ex_mem_result, 32'hF800_0000);
        step(1'b1, 8'h03, 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("slt", ex_mem_result, 32'd1);
        step(1'b1, 8'h04, 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("sltu", ex_mem_result, 32'd0);

        // Downstream stall, then drain and replace in the same cycle.
        step(1'b1, 8'h10, 32'd3, 32'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h01, 32'd9, 32'd9, 1'b0);
            check("stall.hold", ex_mem_result, 32'd7);
        end
        step(1'b1, 8'h05, 32'hF0, 32'h0F, 1'b1);
        check("replace", ex_mem_result, 32'hFF);
        check("replace.valid", {31'd0, ex_mem_valid}, 32'd1);

`ifdef EX_MUL_EN
        step(1'b1, 8'h0A, 32'h0001_0003, 32'h0002_0005, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, 8'h00, 32'd1, 32'd2, 1'b1);
        check("mul", ex_mem_result, 32'h000B_000F);
        step(1'b1, 8'h00, 32'd1, 32'd2, 1'b1);
        check("add_after_mul", ex_mem_result, 32'd3);
        step(1'b1, 8'h1A, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 32'd0, 32'd0, 1'b1);
        pulse_reset();
        for (int i = 0; i < 36; i++) step(1'b0, 8'h00, 32'd0, 32'd0, 1'b1);
`else
        step(1'b1, 8'h0A, 32'h0001_0003, 32'h0002_0005, 1'b1);
        check("mul_off.illegal", {31'd0, ex_mem_illegal}, 32'd1);
        check("mul_off.result", ex_mem_result, 32'd0);
        step(1'b1, 8'h00, 32'd1, 32'd2, 1'b0);
        pulse_reset();
        step(1'b0, 8'h00, 32'd0, 32'd0, 1'b1);
`endif
        step(1'b1, 8'h0D, 32'hDEAD_BEEF, 32'd1, 1'b1);
        check("op13.illegal", {31'd0, ex_mem_illegal}, 32'd1);
        check("op13.result", ex_mem_result, 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 34; i++) step(1'b0, 8'h00, 32'd0, 32'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port res_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port id_ex_valid, input, 1 bit: the decode stage presents a valid operation.
REQ-004 SHALL have port id_ex_control, input, 8 bits: [3:0] ALU op, [4] write-back enable, [7:5] pass-through tag.
REQ-005 SHALL have port id_ex0, input, 32 bits: operand A.
REQ-006 SHALL have port id_ex1, input, 32 bits: operand B.
REQ-007 SHALL have port id_ex_ready, output, 1 bit: the stage accepts an operation this cycle.
REQ-008 SHALL have port mem_ready, input, 1 bit: the downstream stage accepts the current result.
REQ-009 SHALL have port ex_mem_valid, output, 1 bit: a result is held.
REQ-010 SHALL have port ex_mem_result, output, 32 bits: the ALU result.
REQ-011 SHALL have port ex_mem_control, output, 8 bits: id_ex_control of the operation, copied unchanged.
REQ-012 SHALL have port ex_mem_zero, output, 1 bit: ex_mem_result == 0.
REQ-013 SHALL have port ex_mem_illegal, output, 1 bit: the op code was undefined.

Function
REQ-014 An operation SHALL be accepted at a rising edge where id_ex_valid && id_ex_ready.
REQ-015 id_ex_ready SHALL be (state==IDLE) && (!ex_mem_valid || mem_ready), decoded combinationally from registered state and mem_ready.
REQ-016 Op codes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL (low 32 bits), 11 PASS B.
REQ-017 Shift amount SHALL be id_ex1[4:0]; add, sub and mul SHALL wrap modulo 2^32; SLT and SLTU SHALL yield 32'd1 or 32'd0.
REQ-018 Ops 12-15 SHALL produce result 0 with ex_mem_illegal=1; all other ops SHALL produce ex_mem_illegal=0.
REQ-019 For a single-cycle op accepted at edge N, ex_mem_valid, result, control, zero and illegal SHALL be registered at edge N (one-cycle latency).
REQ-020 The state machine SHALL have two states, IDLE and BUSY; accepting MUL SHALL go IDLE->BUSY and latch the operands and control.
REQ-021 BUSY SHALL run a radix-2 shift-add loop on a 6-bit counter, 32 iterations, one per cycle.
REQ-022 The result SHALL be written on the 32nd edge after acceptance, with a return to IDLE on that same edge.
REQ-023 While ex_mem_valid && !mem_ready, all ex_mem_* outputs SHALL hold stable.
REQ-024 ex_mem_valid SHALL clear at an edge where mem_ready=1 and no new result is written.
REQ-025 A new accept SHALL be allowed in the same cycle as a downstream drain; the result is replaced without a bubble.
REQ-026 Inputs presented while id_ex_ready=0 SHALL be ignored.
REQ-027 During BUSY, id_ex_ready SHALL be 0 and ex_mem_valid SHALL be 0 once the prior result has drained.
REQ-028 ex_mem_zero SHALL be registered alongside the result, not derived from the live inputs.

Reset
REQ-029 res_n=0 SHALL, asynchronously, force state to IDLE, clear the counter, and set ex_mem_valid=0, ex_mem_result=0, ex_mem_control=0, ex_mem_zero=0, ex_mem_illegal=0.
REQ-030 Reset during BUSY SHALL abort the multiply with no result emitted; the first accept after release SHALL behave as from power-up.
REQ-031 id_ex_ready SHALL be 1 in the first cycle after res_n rises.

Configuration
REQ-032 The macro EX_MUL_EN SHALL control MUL support: when defined, op 10 SHALL execute per REQ-020..022.
REQ-033 When EX_MUL_EN is undefined, op 10 SHALL be treated as illegal per REQ-018, BUSY SHALL be unreachable and the multiplier logic SHALL be absent.

Verification
REQ-034 SHALL cover: ADD, A=0x7FFFFFFF, B=1, mem_ready=1 -> next cycle result 0x80000000, zero=0, valid=1.
REQ-035 SHALL cover: SUB, A=5, B=5, control=8'h11 -> result 0, zero=1, ex_mem_control=8'h11.
REQ-036 SHALL cover: SRA, A=0x80000000, B=0x24 -> result 0xF8000000 (shift 4); SLT, A=0xFFFFFFFF, B=1 -> result 1; SLTU with the same operands -> result 0.
REQ-037 SHALL cover: MUL (EX_MUL_EN), A=0x00010003, B=0x00020005 -> ready low 32 cycles, then result 0x000B000F; back-to-back ADD held off until IDLE.
REQ-038 SHALL cover: mem_ready=0 for 3 cycles after a result -> outputs stable and ready=0; then mem_ready=1 with a new op -> replaced with no bubble.
REQ-039 SHALL cover: res_n pulsed low at cycle 10 of a MUL -> valid=0 and all outputs 0 immediately, ready=1 after release; op 13 -> illegal=1, result 0.
